// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesters/UART side and the arbiter.
// Handshake: a requester holds req_valid with its byte on req_data; the arbiter
// answers with a one-cycle, one-hot req_ready pulse and has already captured the
// byte on the edge that raised it, so the requester may present its next byte
// (or drop valid) from that cycle on. tx_start is a one-cycle pulse that qualifies
// tx_data; tx_busy is the UART's frame-in-progress flag.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;

  // Environment side: requesters plus the UART's busy flag.
  modport master (
    output req_valid, req_data, req_lock, tx_busy,
    input  req_ready, tx_start, tx_data
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_lock, tx_busy,
    output req_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART byte transmitter among NREQ
// requesters, with optional locked bursts and a watchdog for a stuck UART.
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int TO_CYCLES = 60000,
  parameter int TO_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  uart_tx_arbiter_if.slave        bus,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    active,
  output logic                    err_timeout,
  output logic [1:0]              fsm_state
);

  localparam int GW = $clog2(NREQ);
  localparam logic [GW-1:0]   LAST    = GW'(NREQ - 1);
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TO_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          state;
  logic [GW-1:0]   ptr;
  logic [TO_W-1:0] wd_cnt;

  logic            pick_found;
  logic [GW-1:0]   pick_id;
  logic [GW-1:0]   cand;
  logic [7:0]      pick_data;
  logic [7:0]      cur_data;
  logic            cur_keep;
  logic [GW-1:0]   nxt_ptr;
  logic            wd_expire;

  function automatic logic [NREQ-1:0] one_hot(input logic [GW-1:0] i);
    one_hot    = '0;
    one_hot[i] = 1'b1;
  endfunction

  // Round-robin search starting at ptr, wrapping at NREQ-1 back to 0.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_found && bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
      cand = (cand == LAST) ? '0 : cand + GW'(1);
    end
  end

  assign pick_data = bus.req_data[8*int'(pick_id) +: 8];
  assign cur_data  = bus.req_data[8*int'(grant_id) +: 8];
  // The current owner keeps the transmitter only while it both locks and has a byte.
  assign cur_keep  = bus.req_lock[grant_id] && bus.req_valid[grant_id];
  assign nxt_ptr   = (grant_id == LAST) ? '0 : grant_id + GW'(1);
  // Fires on the edge where the counter would reach TO_CYCLES-1.
  assign wd_expire = (wd_cnt == WD_LAST);
  assign fsm_state = state;

  // Sequencer FSM with all outputs registered; pulse outputs default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      wd_cnt        <= '0;
      bus.req_ready <= '0;
      bus.tx_start  <= 1'b0;
      bus.tx_data   <= 8'h00;
      grant_id      <= '0;
      active        <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      bus.req_ready <= '0;
      bus.tx_start  <= 1'b0;
      err_timeout   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id      <= pick_id;
            bus.tx_data   <= pick_data;
            bus.req_ready <= one_hot(pick_id);
            bus.tx_start  <= 1'b1;
            active        <= 1'b1;
            state         <= START;
          end
        end
        START: begin
          wd_cnt <= '0;
          state  <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (wd_expire) begin
            err_timeout <= 1'b1;
            ptr         <= nxt_ptr;
            active      <= 1'b0;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + TO_W'(1);
            if (bus.tx_busy) state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (wd_expire) begin
            err_timeout <= 1'b1;
            ptr         <= nxt_ptr;
            active      <= 1'b0;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + TO_W'(1);
            if (!bus.tx_busy) begin
              if (cur_keep) begin
                // Locked burst: re-accept the same requester without re-arbitrating.
                bus.tx_data   <= cur_data;
                bus.req_ready <= one_hot(grant_id);
                bus.tx_start  <= 1'b1;
                state         <= START;
              end else begin
                ptr    <= nxt_ptr;
                active <= 1'b0;
                state  <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a 4-requester instance for the main scenarios and
// a 3-requester instance for the non-power-of-two pointer wrap.
module tb_uart_tx_arbiter;
  localparam int NREQ      = 4;
  localparam int TO_CYCLES = 200;
  localparam int TO_W      = 8;
  localparam int FRAME     = 20;   // cycles tx_busy stays high per frame

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(4)) bus4 ();
  uart_tx_arbiter_if #(.NREQ(3)) bus3 ();
  logic [1:0] gid4, gid3, st4, st3;
  logic       act4, act3, err4, err3;

  uart_tx_arbiter #(.NREQ(4), .TO_CYCLES(TO_CYCLES), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave),
    .grant_id(gid4), .active(act4), .err_timeout(err4), .fsm_state(st4)
  );

  uart_tx_arbiter #(.NREQ(3), .TO_CYCLES(TO_CYCLES), .TO_W(TO_W)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave),
    .grant_id(gid3), .active(act3), .err_timeout(err3), .fsm_state(st3)
  );

  // ---------------- bench state ----------------
  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int proto_bad = 0;
  int err_total = 0;
  int model_ptr = 0;
  int u_cnt  = 0;
  int u3_cnt = 0;
  bit uart_dead = 1'b0;
  logic [NREQ-1:0] lock_mask = '0;

  logic [7:0] src_q[NREQ][$];   // bytes the requesters still have to send
  logic [7:0] ref_q[NREQ][$];   // same bytes, consumed by the reference model
  logic [7:0] src3_q[3][$];

  int         acc_id_q[$];
  logic [7:0] acc_data_q[$];
  int         acc_cyc_q[$];
  logic [7:0] uart_q[$];        // bytes the UART model actually started
  int         err_cyc_q[$];
  int         acc3_id_q[$];
  logic [7:0] acc3_data_q[$];

  int         exp_id_q[$];
  logic [7:0] exp_q[$];
  int         exp_gap_q[$];

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    acc_id_q.delete(); acc_data_q.delete(); acc_cyc_q.delete();
    uart_q.delete(); err_cyc_q.delete();
    exp_id_q.delete(); exp_q.delete(); exp_gap_q.delete();
  endtask

  task automatic load(input int i, input logic [7:0] b);
    src_q[i].push_back(b);
    ref_q[i].push_back(b);
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus4.req_valid[i]        = (src_q[i].size() > 0);
      bus4.req_data[8*i +: 8]  = (src_q[i].size() > 0) ? src_q[i][0] : 8'($urandom_range(0, 255));
      bus4.req_lock[i]         = lock_mask[i];
    end
    for (int i = 0; i < 3; i++) begin
      bus3.req_valid[i]        = (src3_q[i].size() > 0);
      bus3.req_data[8*i +: 8]  = (src3_q[i].size() > 0) ? src3_q[i][0] : 8'($urandom_range(0, 255));
      bus3.req_lock[i]         = 1'b0;
    end
    bus4.tx_busy = (u_cnt > 0) && (u_cnt <= FRAME);
    bus3.tx_busy = (u3_cnt > 0) && (u3_cnt <= FRAME);
  endtask

  // One clock: sample outputs just after the edge, log acceptances, run the
  // UART models, then update requester inputs.
  task automatic step();
    int id;
    logic [7:0] dummy;
    @(posedge clk); #1;
    cyc++;
    if (bus4.req_ready != '0) begin
      id = 0;
      for (int k = 0; k < NREQ; k++) if (bus4.req_ready[k]) id = k;
      if (!$onehot(bus4.req_ready) || !bus4.tx_start || err4 || int'(gid4) != id) proto_bad++;
      acc_id_q.push_back(id); acc_data_q.push_back(bus4.tx_data); acc_cyc_q.push_back(cyc);
      if (src_q[id].size() > 0) dummy = src_q[id].pop_front(); else proto_bad++;
    end else if (bus4.tx_start) proto_bad++;
    if (err4) begin err_cyc_q.push_back(cyc); err_total++; end
    if (bus3.req_ready != '0) begin
      id = 0;
      for (int k = 0; k < 3; k++) if (bus3.req_ready[k]) id = k;
      if (!$onehot(bus3.req_ready) || !bus3.tx_start || err3 || int'(gid3) != id) proto_bad++;
      acc3_id_q.push_back(id); acc3_data_q.push_back(bus3.tx_data);
      if (src3_q[id].size() > 0) dummy = src3_q[id].pop_front(); else proto_bad++;
    end else if (bus3.tx_start) proto_bad++;
    if (err3) err_total++;
    // UART model: busy rises the cycle after tx_start and stays high FRAME cycles.
    if (u_cnt > 0) u_cnt--;
    if (bus4.tx_start && !uart_dead) begin u_cnt = FRAME + 1; uart_q.push_back(bus4.tx_data); end
    if (u3_cnt > 0) u3_cnt--;
    if (bus3.tx_start) u3_cnt = FRAME + 1;
    drive();
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    step();
    while (n < max_cyc &&
           !(src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
             src_q[3].size() == 0 && src3_q[0].size() == 0 && src3_q[1].size() == 0 &&
             src3_q[2].size() == 0 && st4 == 2'd0 && st3 == 2'd0 && u_cnt == 0 && u3_cnt == 0)) begin
      step();
      n++;
    end
    check({tag, "_drained"}, 32'(n < max_cyc), 32'd1);
  endtask

  // ---------------- reference model ----------------
  // Transaction-level round robin over the queued bytes: a locked owner that
  // still has bytes keeps the grant, otherwise the pointer moves past it and the
  // next non-empty requester from the pointer wins. With the UART model, tx_busy
  // falls FRAME+1 cycles after tx_start; a burst restarts one cycle later and a
  // released grant goes through IDLE first, one more cycle.
  task automatic run_ref(input logic [NREQ-1:0] lk);
    int g;
    int idx;
    bit cont;
    g = -1;
    for (int n = 0; n < 64; n++) begin
      cont = (g >= 0) && lk[g] && (ref_q[g].size() > 0);
      if (g >= 0 && !cont) begin
        model_ptr = (g + 1) % NREQ;
        g = -1;
      end
      if (g < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (model_ptr + k) % NREQ;
          if (g < 0 && ref_q[idx].size() > 0) g = idx;
        end
      end
      if (g < 0) break;
      exp_gap_q.push_back(cont ? FRAME + 2 : FRAME + 3);
      exp_id_q.push_back(g);
      exp_q.push_back(ref_q[g].pop_front());
    end
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_count"}, 32'(acc_id_q.size()), 32'(exp_id_q.size()));
    check({tag, "_uart_count"}, 32'(uart_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_id_q.size() && i < acc_id_q.size(); i++) begin
      check($sformatf("%s_id%0d", tag, i), 32'(acc_id_q[i]), 32'(exp_id_q[i]));
      check($sformatf("%s_data%0d", tag, i), 32'(acc_data_q[i]), 32'(exp_q[i]));
      if (i < uart_q.size()) check($sformatf("%s_uart%0d", tag, i), 32'(uart_q[i]), 32'(exp_q[i]));
      if (i > 0) check($sformatf("%s_gap%0d", tag, i), 32'(acc_cyc_q[i] - acc_cyc_q[i-1]), 32'(exp_gap_q[i]));
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"},  32'(bus4.req_ready), 32'd0);
    check({tag, "_start"},  32'(bus4.tx_start),  32'd0);
    check({tag, "_data"},   32'(bus4.tx_data),   32'd0);
    check({tag, "_grant"},  32'(gid4),           32'd0);
    check({tag, "_active"}, 32'(act4),           32'd0);
    check({tag, "_err"},    32'(err4),           32'd0);
    check({tag, "_state"},  32'(st4),            32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int total;
    int exp3_id[3];
    logic [7:0] exp3_data[3];
    bit seen_busy;
    exp3_id   = '{1, 2, 0};
    exp3_data = '{8'h71, 8'h72, 8'h70};

    drive();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    check("por_ready3", 32'(bus3.req_ready), 32'd0);
    rst_n = 1'b1;
    step();

    // Fairness: all four valid with two bytes each.
    clear_logs();
    for (int r = 0; r < 2; r++) for (int i = 0; i < NREQ; i++) load(i, 8'(8'h10 + i));
    run_ref('0);
    drive();
    drain("fair", 1000);
    compare_log("fair");

    // Single request on requester 2.
    clear_logs();
    load(2, 8'hA5);
    run_ref('0);
    drive();
    n = 0;
    while (acc_id_q.size() == 0 && n < 10) begin step(); n++; end
    check("single_ready", 32'(bus4.req_ready), 32'h4);
    check("single_start", 32'(bus4.tx_start), 32'd1);
    check("single_txdata", 32'(bus4.tx_data), 32'hA5);
    check("single_grant", 32'(gid4), 32'd2);
    seen_busy = 1'b0;
    n = 0;
    while (!(seen_busy && !bus4.tx_busy) && n < FRAME + 20) begin
      if (bus4.tx_busy) seen_busy = 1'b1;
      step();
      n++;
    end
    check("single_busy_fell", 32'(seen_busy && !bus4.tx_busy), 32'd1);
    check("single_active_at_fall", 32'(act4), 32'd1);
    step();
    check("single_active_after", 32'(act4), 32'd0);
    drain("single", 100);
    compare_log("single");

    // One byte on requester 0 moves the pointer to 1.
    clear_logs();
    load(0, 8'($urandom_range(0, 255)));
    run_ref('0);
    drive();
    drain("r0", 100);
    compare_log("r0");

    // Locked burst on requester 1 while requester 0 waits.
    clear_logs();
    lock_mask = 4'b0010;
    load(1, 8'h31); load(1, 8'h32); load(1, 8'h33);
    load(0, 8'h40);
    run_ref(lock_mask);
    drive();
    drain("lock", 500);
    compare_log("lock");
    lock_mask = '0;

    // Watchdog: the UART never raises busy for requester 1's byte.
    clear_logs();
    uart_dead = 1'b1;
    src_q[1].push_back(8'h61);
    src_q[2].push_back(8'h62);
    drive();
    n = 0;
    while (err_cyc_q.size() == 0 && n < TO_CYCLES + 20) begin step(); n++; end
    check("wd_fired", 32'(err_cyc_q.size()), 32'd1);
    if (err_cyc_q.size() > 0 && acc_cyc_q.size() > 0) begin
      check("wd_delay", 32'(err_cyc_q[0] - acc_cyc_q[0]), 32'(TO_CYCLES));
      check("wd_active", 32'(act4), 32'd0);
      check("wd_state", 32'(st4), 32'd0);
      check("wd_no_ready", 32'(bus4.req_ready), 32'd0);
    end
    uart_dead = 1'b0;
    drain("wd", 500);
    check("wd_count", 32'(acc_id_q.size()), 32'd2);
    if (acc_id_q.size() == 2) begin
      check("wd_first", 32'(acc_id_q[0]), 32'd1);
      check("wd_next", 32'(acc_id_q[1]), 32'd2);
      check("wd_regrant_gap", 32'(acc_cyc_q[1] - acc_cyc_q[0]), 32'(TO_CYCLES + 1));
    end
    check("wd_uart_count", 32'(uart_q.size()), 32'd1);
    if (uart_q.size() == 1) check("wd_uart_byte", 32'(uart_q[0]), 32'h62);
    model_ptr = 3;   // timeout on 1 advanced to 2; 2 then completed

    // Randomized rounds with random locks.
    for (int r = 0; r < 4; r++) begin
      clear_logs();
      lock_mask = 4'($urandom_range(0, 15));
      total = 0;
      for (int i = 0; i < NREQ; i++) begin
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) load(i, 8'($urandom_range(0, 255)));
        total += n;
      end
      if (total == 0) load(r, 8'($urandom_range(0, 255)));
      run_ref(lock_mask);
      drive();
      drain($sformatf("rnd%0d", r), 2000);
      compare_log($sformatf("rnd%0d", r));
    end
    lock_mask = '0;

    // Reset during WAIT_DONE.
    clear_logs();
    src_q[1].push_back(8'h55);
    drive();
    n = 0;
    while (st4 != 2'd3 && n < 10) begin step(); n++; end
    check("mid_reached_wait_done", 32'(st4), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_reset("mid");
    u_cnt = 0; u3_cnt = 0;
    drive();
    step(); step();
    rst_n = 1'b1;
    model_ptr = 0;
    clear_logs();
    load(3, 8'h33); load(0, 8'h30);
    run_ref('0);
    drive();
    drain("after_rst", 200);
    compare_log("after_rst");

    // NREQ=3 wrap: requester 1 moves the pointer to 2, then 2 and 0 compete.
    acc3_id_q.delete(); acc3_data_q.delete();
    src3_q[1].push_back(8'h71);
    drive();
    drain("w3a", 200);
    src3_q[2].push_back(8'h72);
    src3_q[0].push_back(8'h70);
    drive();
    drain("w3b", 200);
    check("wrap3_count", 32'(acc3_id_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < acc3_id_q.size(); i++) begin
      check($sformatf("wrap3_id%0d", i), 32'(acc3_id_q[i]), 32'(exp3_id[i]));
      check($sformatf("wrap3_data%0d", i), 32'(acc3_data_q[i]), 32'(exp3_data[i]));
    end

    check("protocol_violations", 32'(proto_bad), 32'd0);
    check("timeouts_total", 32'(err_total), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
